// File: rtl/wb_decode_pkg.sv
// Shared definitions for the wb_decode_n address decoder: FSM encoding,
// default error data and the user-project address regions.
package wb_decode_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ERR  = 2'd2
   } state_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   localparam logic [7:0] USER_IP  = 8'h30;
   localparam logic [7:0] USER_MEM = 8'h38;

   localparam logic [15:0] STAT_MAX = 16'hFFFF;

   // Slave index width; never zero so a single-slave build still has a real vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_decode_n_if.sv
// Master-facing Wishbone signals of the user-project decoder.
interface wb_decode_n_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i,
      input  wbs_stb_i,
      input  wbs_adr_i,
      output wbs_ack_o,
      output wbs_dat_o
   );

   modport master (
      output wbs_cyc_i,
      output wbs_stb_i,
      output wbs_adr_i,
      input  wbs_ack_o,
      input  wbs_dat_o
   );
endinterface

// File: rtl/wb_addr_match.sv
// Combinational base/mask address match; the lowest matching slave index wins.
module wb_addr_match
   import wb_decode_pkg::*;
#(
   parameter int                      NUM_SLV    = 5,
   parameter logic [NUM_SLV*32-1:0]   BASE_ADDRS = '0,
   parameter logic [NUM_SLV*32-1:0]   ADDR_MASKS = '0,
   parameter int                      IDX_W      = idx_width(NUM_SLV)
) (
   input  logic [31:0]      adr_i,
   output logic             hit_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [NUM_SLV-1:0] hit_vec;

   generate
      for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_cmp
         assign hit_vec[gi] = ((adr_i & ADDR_MASKS[32*gi +: 32]) ==
                               (BASE_ADDRS[32*gi +: 32] & ADDR_MASKS[32*gi +: 32]));
      end
   endgenerate

   // Scan from the top so the lowest hitting index is the last one written.
   always_comb begin
      hit_o = |hit_vec;
      idx_o = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            idx_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/wb_decode_n.sv
// N-slave Wishbone decoder with registered slave select, ack/data routing and
// miss/timeout termination. Define WB_DECODE_STATS_EN for the error counters on stat_o.
module wb_decode_n
   import wb_decode_pkg::*;
#(
   parameter int                    NUM_SLV     = 5,
   parameter logic [NUM_SLV*32-1:0] BASE_ADDRS  = {{USER_IP, 24'h00_0300}, {USER_IP, 24'h00_0200},
                                                   {USER_IP, 24'h00_0100}, {USER_IP, 24'h00_0000},
                                                   {USER_MEM, 24'h00_0000}},
   parameter logic [NUM_SLV*32-1:0] ADDR_MASKS  = {{4{32'hFF00_0F00}}, 32'hFF00_0000},
   parameter int                    TIMEOUT_CYC = 255,
   parameter logic [31:0]           ERR_DATA    = ERR_DATA_DEFAULT
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   wb_decode_n_if.slave            wbs,
   output logic [NUM_SLV-1:0]      slv_valid_o,
   input  logic [NUM_SLV-1:0]      slv_ack_i,
   input  logic [NUM_SLV*32-1:0]   slv_dat_i,
   output logic                    bus_err_o,
   output logic [31:0]             stat_o
);

   localparam int          IDX_W   = idx_width(NUM_SLV);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      cnt_q, cnt_d;

   logic             match_hit;
   logic [IDX_W-1:0] match_idx;
   logic             sel_ack;
   logic [31:0]      sel_dat;
   logic [NUM_SLV-1:0] sel_onehot;
   logic             req;

   assign req = wbs.wbs_cyc_i & wbs.wbs_stb_i;

   wb_addr_match #(
      .NUM_SLV    (NUM_SLV),
      .BASE_ADDRS (BASE_ADDRS),
      .ADDR_MASKS (ADDR_MASKS),
      .IDX_W      (IDX_W)
   ) u_match (
      .adr_i (wbs.wbs_adr_i),
      .hit_o (match_hit),
      .idx_o (match_idx)
   );

   // Route only the latched slave's ack/data; other slaves are never observed.
   always_comb begin
      sel_ack    = 1'b0;
      sel_dat    = '0;
      sel_onehot = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_ack       = slv_ack_i[i];
            sel_dat       = slv_dat_i[32*i +: 32];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (match_hit) begin
                  idx_d   = match_idx;
                  cnt_d   = '0;
                  state_d = BUSY;
               end else begin
                  state_d = ERR;
               end
            end
         end
         BUSY: begin
            // A selected ack outranks a simultaneous cyc drop.
            if (sel_ack) begin
               state_d = IDLE;
            end else if (!wbs.wbs_cyc_i) begin
               state_d = IDLE;
            end else if (cnt_q == TO_LAST) begin
               state_d = ERR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      slv_valid_o   = '0;
      wbs.wbs_ack_o = 1'b0;
      wbs.wbs_dat_o = '0;
      bus_err_o     = 1'b0;
      case (state_q)
         BUSY: begin
            slv_valid_o = sel_onehot;
            if (sel_ack) begin
               wbs.wbs_ack_o = 1'b1;
               wbs.wbs_dat_o = sel_dat;
            end
         end
         ERR: begin
            wbs.wbs_ack_o = 1'b1;
            wbs.wbs_dat_o = ERR_DATA;
            bus_err_o     = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef WB_DECODE_STATS_EN
   logic [15:0] miss_cnt_q, to_cnt_q;
   logic        miss_evt, to_evt;

   assign miss_evt = (state_q == IDLE) && (state_d == ERR);
   assign to_evt   = (state_q == BUSY) && (state_d == ERR);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         miss_cnt_q <= '0;
         to_cnt_q   <= '0;
      end else begin
         if (miss_evt && (miss_cnt_q != STAT_MAX)) miss_cnt_q <= miss_cnt_q + 16'd1;
         if (to_evt && (to_cnt_q != STAT_MAX))     to_cnt_q   <= to_cnt_q + 16'd1;
      end
   end

   assign stat_o = {miss_cnt_q, to_cnt_q};
`else
   assign stat_o = '0;
`endif

endmodule

// File: tb/tb_wb_decode_n.sv
// Directed bench for wb_decode_n: expected master responses are queued at issue
// time and checked by an independent ack monitor.
module tb_wb_decode_n;

   localparam int          NUM_SLV = 5;
   localparam logic [31:0] DEAD    = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [31:0] dat;
      logic        err;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_SLV-1:0]    slv_valid;
   logic [NUM_SLV-1:0]    slv_ack;
   logic [NUM_SLV*32-1:0] slv_dat;
   logic                  bus_err;
   logic [31:0]           stat;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   exp_misses = 0;
   int   exp_touts  = 0;

   wb_decode_n_if wb();

   wb_decode_n #(
      .NUM_SLV     (NUM_SLV),
      .TIMEOUT_CYC (8)
   ) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wbs         (wb),
      .slv_valid_o (slv_valid),
      .slv_ack_i   (slv_ack),
      .slv_dat_i   (slv_dat),
      .bus_err_o   (bus_err),
      .stat_o      (stat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] onehot(input int s);
      logic [31:0] v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

   // Monitor: every master ack consumes one queued expectation.
   exp_t e;
   always @(negedge clk) begin
      if (wb.wbs_ack_o === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_ack: got ack with data %h, expected no ack", wb.wbs_dat_o);
         end else begin
            e = sb.pop_front();
            check("ack_data", wb.wbs_dat_o, e.dat);
            check("ack_err", {31'b0, bus_err}, {31'b0, e.err});
            $display("ack: data=%h bus_err=%b", wb.wbs_dat_o, bus_err);
         end
      end else if (bus_err !== 1'b0) begin
         n_vec++;
         n_miss++;
         $display("FAIL err_without_ack: got bus_err %b, expected 0", bus_err);
      end
   end

   task automatic check_stat();
`ifdef WB_DECODE_STATS_EN
      check("stat", stat, {exp_misses[15:0], exp_touts[15:0]});
`else
      check("stat", stat, 32'h0);
`endif
   endtask

   task automatic issue(input logic [31:0] adr);
      tick();
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_adr_i = adr;
   endtask

   task automatic end_cycle();
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      slv_ack      = '0;
   endtask

   // Slave acks 'delay' cycles after valid rises; optional spurious ack from another slave.
   task automatic read_ok(input logic [31:0] adr, input int slv, input int delay,
                          input logic [31:0] data, input int spur);
      $display("read %h slave %0d delay %0d", adr, slv, delay);
      sb.push_back('{dat: data, err: 1'b0});
      issue(adr);
      tick();
      if (delay == 0) begin
         slv_ack[slv]          = 1'b1;
         slv_dat[32*slv +: 32] = data;
      end
      @(negedge clk);
      check("valid_sel", 32'(slv_valid), onehot(slv));
      for (int i = 0; i < delay; i++) begin
         tick();
         slv_ack = '0;
         if (i == 0 && spur >= 0) begin
            slv_ack[spur]          = 1'b1;
            slv_dat[32*spur +: 32] = 32'hAAAA_AAAA;
         end
         if (i == delay - 1) begin
            slv_ack[slv]          = 1'b1;
            slv_dat[32*slv +: 32] = data;
         end
      end
      tick();
      end_cycle();
      @(negedge clk);
      check("valid_after_ack", 32'(slv_valid), 32'h0);
      check("dat_idle", wb.wbs_dat_o, 32'h0);
   endtask

   task automatic miss_read(input logic [31:0] adr);
      $display("read %h unmapped", adr);
      sb.push_back('{dat: DEAD, err: 1'b1});
      issue(adr);
      tick();
      @(negedge clk);
      check("miss_valid", 32'(slv_valid), 32'h0);
      tick();
      end_cycle();
      exp_misses++;
      @(negedge clk);
      check("miss_ack_gone", {31'b0, wb.wbs_ack_o}, 32'h0);
      check_stat();
   endtask

   task automatic timeout_read(input logic [31:0] adr, input int slv);
      $display("read %h slave %0d never acks", adr, slv);
      sb.push_back('{dat: DEAD, err: 1'b1});
      issue(adr);
      for (int k = 0; k < 8; k++) begin
         tick();
         @(negedge clk);
         check("to_valid", 32'(slv_valid), onehot(slv));
      end
      tick();
      @(negedge clk);
      check("to_valid_drop", 32'(slv_valid), 32'h0);
      tick();
      end_cycle();
      exp_touts++;
      @(negedge clk);
      check("to_ack_gone", {31'b0, wb.wbs_ack_o}, 32'h0);
      check_stat();
   endtask

   task automatic cyc_drop(input logic [31:0] adr, input int slv);
      $display("read %h slave %0d abandoned by master", adr, slv);
      issue(adr);
      tick();
      @(negedge clk);
      check("drop_valid", 32'(slv_valid), onehot(slv));
      tick();
      tick();
      end_cycle();
      tick();
      slv_ack[slv]          = 1'b1;
      slv_dat[32*slv +: 32] = 32'hBAD0_0004;
      @(negedge clk);
      check("drop_valid_clr", 32'(slv_valid), 32'h0);
      check("drop_no_ack", {31'b0, wb.wbs_ack_o}, 32'h0);
      tick();
      slv_ack = '0;
   endtask

   task automatic reset_mid(input logic [31:0] adr, input int slv);
      $display("read %h slave %0d interrupted by reset", adr, slv);
      issue(adr);
      tick();
      @(negedge clk);
      check("rst_pre_valid", 32'(slv_valid), onehot(slv));
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      end_cycle();
      slv_ack[slv]          = 1'b1;
      slv_dat[32*slv +: 32] = 32'hBAD0_0002;
      @(negedge clk);
      check("rst_valid", 32'(slv_valid), 32'h0);
      check("rst_ack", {31'b0, wb.wbs_ack_o}, 32'h0);
      check("rst_dat", wb.wbs_dat_o, 32'h0);
      check("rst_err", {31'b0, bus_err}, 32'h0);
      tick();
      slv_ack = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Slave order follows the [32*i+31:32*i] packing: slave 0 = 0x38xx_xxxx,
   // slaves 1..4 = 0x3000_0000 / 0100 / 0200 / 0300.
   initial begin
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_adr_i = '0;
      slv_ack      = '0;
      slv_dat      = '0;
      rst          = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      check("reset_valid", 32'(slv_valid), 32'h0);
      check("reset_ack", {31'b0, wb.wbs_ack_o}, 32'h0);
      check("reset_dat", wb.wbs_dat_o, 32'h0);
      check("reset_err", {31'b0, bus_err}, 32'h0);
      check("reset_stat", stat, 32'h0);
      tick();
      rst = 1'b0;

      read_ok(32'h3000_0104, 2, 2, 32'h1234_5678, -1);
      miss_read(32'h3000_0F00);
      timeout_read(32'h3800_0010, 0);
      read_ok(32'h3000_0200, 3, 3, 32'h3333_0200, 1);
      cyc_drop(32'h3000_0300, 4);
      reset_mid(32'h3000_0100, 2);
      exp_misses = 0;
      exp_touts  = 0;
      check_stat();
      read_ok(32'h3000_0300, 4, 1, 32'h4444_0300, -1);
      read_ok(32'h3800_0010, 0, 0, 32'h5555_0000, -1);
      read_ok(32'h3000_0000, 1, 4, 32'h1111_0000, 0);

      repeat (3) tick();
      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
